// File: rtl/flag_unit_pkg.sv
// Shared types for the flag unit and its users (ALU, branch unit).
//  FLAG_EQ / FLAG_LT : bit positions of the EQ and LT flags in a 2-bit flag vector
//  cond_e            : 3-bit condition code evaluated against the flags
package flag_unit_pkg;

  localparam int FLAG_EQ = 0;
  localparam int FLAG_LT = 1;

  typedef enum logic [2:0] {
    COND_AL = 3'd0,
    COND_EQ = 3'd1,
    COND_NE = 3'd2,
    COND_LT = 3'd3,
    COND_GE = 3'd4,
    COND_LE = 3'd5,
    COND_GT = 3'd6,
    COND_NV = 3'd7
  } cond_e;

endpackage

// File: rtl/flag_unit_if.sv
// Bundle of the flag unit's pipeline-facing signals.
//  master : EX / multi-cycle / exception side (drives requests, sees stalls and results)
//  slave  : the flag unit itself
//  ex_setflags/ex_flags/ex_stall      EX flag write and its interlock
//  cond_req/cond/cond_true/cond_stall condition evaluation for select/branch
//  mc_issue/mc_ready/mc_done/mc_flags multi-cycle flag producers
//  exc_entry/eret                      exception save/restore
//  flags_q/err                         architectural flags and sticky protocol error
interface flag_unit_if
  import flag_unit_pkg::*;
();
  logic       ex_setflags;
  logic [1:0] ex_flags;
  logic       ex_stall;
  logic       cond_req;
  cond_e      cond;
  logic       cond_true;
  logic       cond_stall;
  logic       mc_issue;
  logic       mc_ready;
  logic       mc_done;
  logic [1:0] mc_flags;
  logic       exc_entry;
  logic       eret;
  logic [1:0] flags_q;
  logic       err;

  modport master (
    output ex_setflags, ex_flags, cond_req, cond, mc_issue, mc_done, mc_flags,
           exc_entry, eret,
    input  ex_stall, cond_true, cond_stall, mc_ready, flags_q, err
  );

  modport slave (
    input  ex_setflags, ex_flags, cond_req, cond, mc_issue, mc_done, mc_flags,
           exc_entry, eret,
    output ex_stall, cond_true, cond_stall, mc_ready, flags_q, err
  );
endinterface

// File: rtl/flag_unit_cond_eval.sv
// Combinational condition evaluator: (flags, cond) -> cond_true.
// Shared with the branch unit, so it holds no state.
//  flags     in  2  EQ/LT flag vector
//  cond      in  3  condition code
//  cond_true out 1  condition result
module flag_unit_cond_eval
  import flag_unit_pkg::*;
(
  input  logic [1:0] flags,
  input  cond_e      cond,
  output logic       cond_true
);

  logic eq_s;
  logic lt_s;

  assign eq_s = flags[FLAG_EQ];
  assign lt_s = flags[FLAG_LT];

  // Decode the condition code against the flags
  always_comb begin
    cond_true = 1'b0;
    case (cond)
      COND_AL: cond_true = 1'b1;
      COND_EQ: cond_true = eq_s;
      COND_NE: cond_true = ~eq_s;
      COND_LT: cond_true = lt_s;
      COND_GE: cond_true = ~lt_s;
      COND_LE: cond_true = eq_s | lt_s;
      COND_GT: cond_true = ~eq_s & ~lt_s;
      COND_NV: cond_true = 1'b0;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_unit.sv
// Architectural EQ/LT flag register with multi-cycle write interlock,
// same-cycle EX bypass into condition evaluation, and exception save/restore.
//  clk  in  clock
//  rst  in  asynchronous active-high reset
//  bus  slave modport of flag_unit_if (see interface for signal list)
// Counters: pending = accepted multi-cycle writes not yet completed;
// drop = completions still owed by ops issued before an exception, which
// must be discarded when they arrive.
module flag_unit
  import flag_unit_pkg::*;
#(
  parameter int MAX_PEND = 4
) (
  input logic        clk,
  input logic        rst,
  flag_unit_if.slave bus
);

  localparam int PEND_W = $clog2(MAX_PEND + 1);
  localparam int DROP_W = $clog2(2 * MAX_PEND + 1);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PEND);

  logic [1:0]        flags_r;
  logic [1:0]        saved_r;
  logic [PEND_W-1:0] pending_r;
  logic [DROP_W-1:0] drop_r;
  logic              err_r;

  logic              busy_s;
  logic              ex_write_s;
  logic [1:0]        eff_s;
  logic              mc_ready_s;
  logic              issue_acc_s;
  logic              done_acc_s;
  logic              done_drop_s;
  logic              done_orphan_s;
  logic [1:0]        flags_nxt_s;
  logic [1:0]        saved_nxt_s;
  logic [PEND_W-1:0] pending_nxt_s;
  logic [DROP_W-1:0] drop_nxt_s;

  assign busy_s     = (pending_r != {PEND_W{1'b0}});
  assign ex_write_s = bus.ex_setflags & ~busy_s;
  // Zero-cycle forward of the EX compare result into condition evaluation
  assign eff_s      = ex_write_s ? bus.ex_flags : flags_r;
  assign mc_ready_s = (pending_r != PEND_MAX);

  // Classify this cycle's multi-cycle issue/completion
  always_comb begin
    issue_acc_s   = bus.mc_issue & mc_ready_s & ~bus.exc_entry;
    done_drop_s   = 1'b0;
    done_acc_s    = 1'b0;
    done_orphan_s = 1'b0;
    if (bus.mc_done) begin
      if (drop_r != {DROP_W{1'b0}}) begin
        done_drop_s = 1'b1;
      end else if (busy_s) begin
        // On exception entry a live completion is dropped instead of accepted
        done_acc_s  = ~bus.exc_entry;
        done_drop_s = bus.exc_entry;
      end else begin
        done_orphan_s = 1'b1;
      end
    end else begin
      done_drop_s = 1'b0;
    end
  end

  // Next-state for flags, saved copy and counters, in priority order
  always_comb begin
    flags_nxt_s   = flags_r;
    saved_nxt_s   = saved_r;
    pending_nxt_s = pending_r;
    drop_nxt_s    = drop_r;
    if (bus.exc_entry) begin
      saved_nxt_s   = eff_s;
      pending_nxt_s = {PEND_W{1'b0}};
      // Outstanding ops become owed drops; a completion arriving now is one of them
      drop_nxt_s    = drop_r + DROP_W'(pending_r) - DROP_W'(done_drop_s);
    end else begin
      if (bus.eret) begin
        flags_nxt_s = saved_r;
      end else if (done_acc_s) begin
        flags_nxt_s = bus.mc_flags;
      end else if (ex_write_s) begin
        flags_nxt_s = bus.ex_flags;
      end else begin
        flags_nxt_s = flags_r;
      end
      pending_nxt_s = pending_r + PEND_W'(issue_acc_s) - PEND_W'(done_acc_s);
      drop_nxt_s    = drop_r - DROP_W'(done_drop_s);
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_r   <= 2'b00;
      saved_r   <= 2'b00;
      pending_r <= {PEND_W{1'b0}};
      drop_r    <= {DROP_W{1'b0}};
      err_r     <= 1'b0;
    end else begin
      flags_r   <= flags_nxt_s;
      saved_r   <= saved_nxt_s;
      pending_r <= pending_nxt_s;
      drop_r    <= drop_nxt_s;
      err_r     <= err_r | done_orphan_s;
    end
  end

  flag_unit_cond_eval u_cond_eval (
    .flags     (eff_s),
    .cond      (bus.cond),
    .cond_true (bus.cond_true)
  );

  assign bus.ex_stall   = bus.ex_setflags & busy_s;
  assign bus.cond_stall = bus.cond_req & busy_s;
  assign bus.mc_ready   = mc_ready_s;
  assign bus.flags_q    = flags_r;
  assign bus.err        = err_r;

endmodule

// File: tb/tb_flag_unit.sv
// Directed self-checking bench for flag_unit (MAX_PEND = 4).
// Inputs change 1 time unit after each rising edge; checks follow the change.
module tb_flag_unit;
  import flag_unit_pkg::*;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  flag_unit_if bus ();

  flag_unit #(.MAX_PEND(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-written truth table: bit f of entry c is the result for cond c, flags f
  logic [3:0] cond_tbl [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] mcv [4];
    logic [3:0] row;
    tests = 0;
    fails = 0;
    cond_tbl[0] = 4'b1111;  // AL
    cond_tbl[1] = 4'b1010;  // EQ
    cond_tbl[2] = 4'b0101;  // NE
    cond_tbl[3] = 4'b1100;  // LT
    cond_tbl[4] = 4'b0011;  // GE
    cond_tbl[5] = 4'b1110;  // LE
    cond_tbl[6] = 4'b0001;  // GT
    cond_tbl[7] = 4'b0000;  // NV
    mcv[0] = 2'b10; mcv[1] = 2'b00; mcv[2] = 2'b11; mcv[3] = 2'b10;

    rst = 1'b1;
    bus.ex_setflags = 1'b0; bus.ex_flags = 2'b00;
    bus.cond_req = 1'b0;    bus.cond = COND_AL;
    bus.mc_issue = 1'b0;    bus.mc_done = 1'b0; bus.mc_flags = 2'b00;
    bus.exc_entry = 1'b0;   bus.eret = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk2("rst_flags", bus.flags_q, 2'b00);
    chk1("rst_err", bus.err, 1'b0);
    chk1("rst_ready", bus.mc_ready, 1'b1);
    chk1("rst_ex_stall", bus.ex_stall, 1'b0);

    // Condition on reset flags, then same-cycle bypass
    bus.cond_req = 1'b1; bus.cond = COND_EQ;
    #1;
    chk1("eq_on_zero", bus.cond_true, 1'b0);
    chk1("cond_stall_idle", bus.cond_stall, 1'b0);
    bus.ex_setflags = 1'b1; bus.ex_flags = 2'b01;
    #1;
    chk1("bypass_eq", bus.cond_true, 1'b1);
    chk1("bypass_no_stall", bus.ex_stall, 1'b0);
    chk2("bypass_flags_old", bus.flags_q, 2'b00);
    tick();
    bus.ex_setflags = 1'b0;
    #1;
    chk2("ex_write", bus.flags_q, 2'b01);

    // Fill to MAX_PEND
    bus.mc_issue = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk1("fill_ready", bus.mc_ready, 1'b1);
      tick();
    end
    chk1("full_ready", bus.mc_ready, 1'b0);
    chk1("full_cond_stall", bus.cond_stall, 1'b1);
    tick();
    chk1("full_still_ready0", bus.mc_ready, 1'b0);
    bus.mc_issue = 1'b0;
    bus.cond = COND_LT;

    // Drain with four completions
    for (int i = 0; i < 4; i++) begin
      bus.mc_done = 1'b1; bus.mc_flags = mcv[i];
      #1;
      chk1("drain_cond_stall", bus.cond_stall, 1'b1);
      tick();
      chk2("drain_flags", bus.flags_q, mcv[i]);
    end
    bus.mc_done = 1'b0;
    #1;
    chk1("drained_cond_stall", bus.cond_stall, 1'b0);
    chk1("drained_cond_lt", bus.cond_true, 1'b1);
    chk1("drained_ready", bus.mc_ready, 1'b1);
    bus.cond_req = 1'b0;

    // Issue and done in one cycle with pending=1, EX write blocked
    bus.mc_issue = 1'b1;
    tick();
    bus.mc_done = 1'b1; bus.mc_flags = 2'b01;
    bus.ex_setflags = 1'b1; bus.ex_flags = 2'b11;
    #1;
    chk1("both_ex_stall", bus.ex_stall, 1'b1);
    tick();
    bus.mc_issue = 1'b0; bus.mc_done = 1'b0;
    #1;
    chk2("both_flags_mc", bus.flags_q, 2'b01);
    chk1("both_pending_kept", bus.ex_stall, 1'b1);
    bus.mc_done = 1'b1; bus.mc_flags = 2'b00;
    tick();
    bus.mc_done = 1'b0;
    #1;
    chk2("last_done_flags", bus.flags_q, 2'b00);
    chk1("unblocked_ex", bus.ex_stall, 1'b0);
    tick();
    bus.ex_setflags = 1'b0;
    #1;
    chk2("ex_after_unblock", bus.flags_q, 2'b11);

    // Exception with two in flight: saved=11, drops owed
    bus.mc_issue = 1'b1;
    tick(); tick();
    bus.mc_issue = 1'b0;
    bus.exc_entry = 1'b1;
    tick();
    bus.exc_entry = 1'b0;
    bus.ex_setflags = 1'b1; bus.ex_flags = 2'b01;
    #1;
    chk1("exc_pending_cleared", bus.ex_stall, 1'b0);
    tick();
    bus.ex_setflags = 1'b0;
    bus.mc_done = 1'b1; bus.mc_flags = 2'b10;
    tick(); tick();
    bus.mc_done = 1'b0;
    #1;
    chk2("dropped_flags", bus.flags_q, 2'b01);
    chk1("dropped_err", bus.err, 1'b0);
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
    #1;
    chk2("eret_restore", bus.flags_q, 2'b11);

    // exc_entry and eret together: save wins, flags hold
    bus.ex_setflags = 1'b1; bus.ex_flags = 2'b00;
    tick();
    bus.ex_flags = 2'b10;
    bus.exc_entry = 1'b1; bus.eret = 1'b1;
    tick();
    bus.ex_setflags = 1'b0; bus.exc_entry = 1'b0;
    #1;
    chk2("exc_eret_hold", bus.flags_q, 2'b00);
    tick();
    bus.eret = 1'b0;
    #1;
    chk2("exc_eret_saved", bus.flags_q, 2'b10);

    // Orphan completion sets sticky err
    chk1("pre_orphan_err", bus.err, 1'b0);
    bus.mc_done = 1'b1; bus.mc_flags = 2'b11;
    tick();
    bus.mc_done = 1'b0;
    #1;
    chk1("orphan_err", bus.err, 1'b1);
    chk2("orphan_flags", bus.flags_q, 2'b10);
    tick(); tick();
    chk1("err_sticky", bus.err, 1'b1);

    // Async reset mid-cycle with pending=3
    bus.mc_issue = 1'b1;
    tick(); tick(); tick();
    bus.mc_issue = 1'b0;
    bus.cond_req = 1'b1;
    #1;
    chk1("pre_rst_stall", bus.cond_stall, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk2("async_rst_flags", bus.flags_q, 2'b00);
    chk1("async_rst_err", bus.err, 1'b0);
    chk1("async_rst_pending", bus.cond_stall, 1'b0);
    #1;
    rst = 1'b0;
    bus.cond_req = 1'b0;
    tick();
    bus.mc_done = 1'b1;
    tick();
    bus.mc_done = 1'b0;
    #1;
    chk1("post_rst_orphan_err", bus.err, 1'b1);

    // Sweep every condition over every flag value via the bypass path
    bus.cond_req = 1'b1;
    bus.ex_setflags = 1'b1;
    for (int c = 0; c < 8; c++) begin
      row = cond_tbl[c];
      for (int f = 0; f < 4; f++) begin
        bus.cond = cond_e'(c[2:0]);
        bus.ex_flags = f[1:0];
        #1;
        chk1($sformatf("sweep_c%0d_f%0d", c, f), bus.cond_true, row[f]);
      end
    end
    bus.ex_setflags = 1'b0;
    bus.cond_req = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
